// File: rtl/p2s_frame_shifter.sv
// Parallel-to-serial frame shifter for a 74HC595-style external chain.
// Each frame is a clear pulse followed by DATA_BITS s_clk cycles, then a one-cycle finish pulse.
module p2s_frame_shifter #(
  parameter int P_CLK_FREQ  = 25,
  parameter int S_CLK_FREQ  = 20,
  parameter int DATA_BITS   = 16,
  parameter int CODE_ENDIAN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  output logic                 busy,
  output logic                 finish,
  output logic                 s_clk,
  output logic                 s_clr,
  output logic                 s_dat
);

  localparam int HRAW = P_CLK_FREQ / (2 * S_CLK_FREQ);
  localparam int H    = (HRAW < 1) ? 1 : HRAW;
  localparam int DW   = (H > 1) ? $clog2(H) : 1;
  localparam int CW   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t               state, nxt;
  logic [DW-1:0]        div, div_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [DATA_BITS-1:0] sreg, sreg_d;
  logic                 clr_ph, clr_ph_d;
  logic                 tick, cur_bit;

  assign tick = (div == DW'(H - 1));

  always_comb begin
    nxt      = state;
    div_d    = div;
    cnt_d    = cnt;
    sreg_d   = sreg;
    clr_ph_d = clr_ph;
    if (state != IDLE) div_d = tick ? '0 : div + DW'(1);
    case (state)
      IDLE: begin
        if (start) begin
          nxt      = CLEAR;
          sreg_d   = data;
          cnt_d    = '0;
          div_d    = '0;
          clr_ph_d = 1'b0;
        end
      end
      // clr_ph marks the second tick so CLEAR spans two half-periods
      CLEAR: begin
        if (tick) begin
          clr_ph_d = 1'b1;
          if (clr_ph) nxt = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (tick) nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          sreg_d = (CODE_ENDIAN != 0) ? (sreg << 1) : (sreg >> 1);
          cnt_d  = cnt + CW'(1);
          nxt    = (cnt == CW'(DATA_BITS - 1)) ? DONE : SHIFT_LO;
        end
      end
      DONE: begin
        nxt   = IDLE;
        div_d = '0;
      end
      default: nxt = IDLE;
    endcase
    cur_bit = (CODE_ENDIAN != 0) ? sreg_d[DATA_BITS-1] : sreg_d[0];
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      div    <= '0;
      cnt    <= '0;
      sreg   <= '0;
      clr_ph <= 1'b0;
      busy   <= 1'b0;
      finish <= 1'b0;
      s_clk  <= 1'b0;
      s_clr  <= 1'b0;
      s_dat  <= 1'b0;
    end else begin
      state  <= nxt;
      div    <= div_d;
      cnt    <= cnt_d;
      sreg   <= sreg_d;
      clr_ph <= clr_ph_d;
      busy   <= (nxt == CLEAR) || (nxt == SHIFT_LO) || (nxt == SHIFT_HI);
      finish <= (nxt == DONE);
      s_clk  <= (nxt == SHIFT_HI);
      s_clr  <= (nxt == CLEAR);
      s_dat  <= ((nxt == SHIFT_LO) || (nxt == SHIFT_HI)) ? cur_bit : 1'b0;
    end
  end

endmodule
